// File: rtl/instruction_memory_interface_pkg.sv
// Shared definitions for the instruction memory interface and its line buffer.
package instruction_memory_interface_pkg;

  localparam int ADDR_W      = 12;
  localparam int WORD_ADDR_W = 10;
  localparam int INSTR_W     = 16;
  localparam int DATA_W      = 32;
  localparam int CNT_W       = 4;

  // ADDS r0,r0,#0 -- also the fetch stage's reset instruction
  localparam logic [INSTR_W-1:0] NOP_INSTR = 16'h1C00;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_WAIT = 2'd1,
    ST_FILL = 2'd2
  } imem_state_e;

  // Little-endian halfword pick out of a 32-bit memory word
  function automatic logic [INSTR_W-1:0] select_half(input logic [DATA_W-1:0] word,
                                                     input logic hi);
    return hi ? word[31:16] : word[15:0];
  endfunction

endpackage

// File: rtl/imem_line_buffer.sv
// One-word line buffer: tag/data/valid storage, hit compare and halfword select.
module imem_line_buffer
  import instruction_memory_interface_pkg::*;
(
  input  logic                   clk,
  input  logic                   reset,
  input  logic [WORD_ADDR_W-1:0] lookup_word,
  input  logic                   lookup_hi,
  input  logic                   wr_en,
  input  logic [WORD_ADDR_W-1:0] wr_tag,
  input  logic [DATA_W-1:0]      wr_data,
  input  logic                   wr_valid,
  input  logic                   clear_valid,
  output logic                   hit,
  output logic [INSTR_W-1:0]     rd_half
);

  logic [WORD_ADDR_W-1:0] tag;
  logic [DATA_W-1:0]      data;
  logic                   line_valid;

  // Fill writes the whole line; a standalone clear only drops the valid bit
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      tag        <= '0;
      data       <= '0;
      line_valid <= 1'b0;
    end else if (wr_en) begin
      tag        <= wr_tag;
      data       <= wr_data;
      line_valid <= wr_valid;
    end else if (clear_valid) begin
      line_valid <= 1'b0;
    end
  end

  assign hit     = line_valid && (tag == lookup_word);
  assign rd_half = select_half(data, lookup_hi);

endmodule

// File: rtl/instruction_memory_interface.sv
// Fetch-side halfword reader in front of a 32-bit instruction memory.
// Hits in the one-word line buffer return next cycle; misses run an
// IDLE -> WAIT -> FILL sequence of READ_LATENCY cycles while stalling fetch.
//
// Handshake: a request is accepted on a rising edge where read_enable=1 and
// stall_memory=0; instruction_out carries the halfword from the next cycle
// until the next accepted request. stall_memory is only ever 1 while
// read_enable is 1. mem_ce is a single-cycle strobe, sampled together with
// mem_addr on the rising edge; mem_rdata is consumed READ_LATENCY cycles later.
module instruction_memory_interface
  import instruction_memory_interface_pkg::*;
#(
  parameter int                 READ_LATENCY = 2,
  parameter logic [INSTR_W-1:0] RESET_INSTR  = NOP_INSTR
) (
  input  logic                   clk,
  input  logic                   reset,
  input  logic                   read_enable,
  input  logic [ADDR_W-1:0]      address,
  input  logic                   invalidate,
  output logic [INSTR_W-1:0]     instruction_out,
  output logic                   stall_memory,
  output logic                   mem_ce,
  output logic [WORD_ADDR_W-1:0] mem_addr,
  input  logic [DATA_W-1:0]      mem_rdata
);

  imem_state_e            state, state_next;
  logic [CNT_W-1:0]       wait_cnt, wait_cnt_next;
  logic                   stale, stale_next;
  logic [WORD_ADDR_W-1:0] mem_addr_q, mem_addr_d;
  logic                   hit;
  logic [INSTR_W-1:0]     rd_half;
  logic                   fill_we;
  logic                   clear_valid;
  logic                   accept;
  logic                   addr_bit0_unused;

  // Byte offset within a halfword carries no information for fetch
  assign addr_bit0_unused = address[0];

  imem_line_buffer u_line_buffer (
    .clk         (clk),
    .reset       (reset),
    .lookup_word (address[11:2]),
    .lookup_hi   (address[1]),
    .wr_en       (fill_we),
    .wr_tag      (mem_addr_q),
    .wr_data     (mem_rdata),
    .wr_valid    (!stale && !invalidate),
    .clear_valid (clear_valid),
    .hit         (hit),
    .rd_half     (rd_half)
  );

  assign stall_memory = read_enable && ((state != ST_IDLE) || !hit);
  assign accept       = read_enable && !stall_memory;
  assign mem_addr     = mem_addr_d;

  // Next-state, strobe and counter logic for the fill sequence
  always_comb begin
    state_next    = state;
    wait_cnt_next = wait_cnt;
    stale_next    = stale;
    mem_addr_d    = mem_addr_q;
    mem_ce        = 1'b0;
    fill_we       = 1'b0;
    clear_valid   = 1'b0;
    case (state)
      ST_IDLE: begin
        clear_valid = invalidate;
        if (read_enable && !hit) begin
          mem_ce        = 1'b1;
          mem_addr_d    = address[11:2];
          stale_next    = 1'b0;
          wait_cnt_next = CNT_W'(READ_LATENCY - 1);
          // With single-cycle memory the data is already there next cycle
          state_next    = (READ_LATENCY == 1) ? ST_FILL : ST_WAIT;
        end
      end
      ST_WAIT: begin
        if (invalidate) stale_next = 1'b1;
        if (wait_cnt != '0) wait_cnt_next = wait_cnt - CNT_W'(1);
        if (wait_cnt <= CNT_W'(1)) state_next = ST_FILL;
      end
      ST_FILL: begin
        fill_we    = 1'b1;
        state_next = ST_IDLE;
      end
      default: state_next = ST_IDLE;
    endcase
  end

  // FSM, wait counter, stale flag and latched memory address
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state      <= ST_IDLE;
      wait_cnt   <= '0;
      stale      <= 1'b0;
      mem_addr_q <= '0;
    end else begin
      state      <= state_next;
      wait_cnt   <= wait_cnt_next;
      stale      <= stale_next;
      mem_addr_q <= mem_addr_d;
    end
  end

  // Registered instruction, updated only on an accepted request
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      instruction_out <= RESET_INSTR;
    end else if (accept) begin
      instruction_out <= rd_half;
    end
  end

endmodule

// File: tb/tb_instruction_memory_interface.sv
// Bench for instruction_memory_interface: directed scenarios on a
// READ_LATENCY=2 instance, model-driven sweep on a READ_LATENCY=1 instance.
module tb_instruction_memory_interface;

  logic        clk = 1'b0;
  logic        reset;
  logic        re_a, inv_a, re_b, inv_b;
  logic [11:0] addr_a, addr_b;
  logic [15:0] out_a, out_b;
  logic        stall_a, stall_b, ce_a, ce_b;
  logic [9:0]  maddr_a, maddr_b;
  logic [31:0] rdata_a, rdata_b;

  int checks = 0;
  int errors = 0;
  int viol_a = 0;
  int viol_b = 0;

  logic [15:0] exp_q_a[$];
  logic [15:0] exp_q_b[$];
  logic [31:0] mem [0:1023];

  // ---------------- clock ----------------
  always #5 clk = ~clk;

  instruction_memory_interface #(.READ_LATENCY(2)) dut_a (
    .clk(clk), .reset(reset), .read_enable(re_a), .address(addr_a),
    .invalidate(inv_a), .instruction_out(out_a), .stall_memory(stall_a),
    .mem_ce(ce_a), .mem_addr(maddr_a), .mem_rdata(rdata_a)
  );

  instruction_memory_interface #(.READ_LATENCY(1)) dut_b (
    .clk(clk), .reset(reset), .read_enable(re_b), .address(addr_b),
    .invalidate(inv_b), .instruction_out(out_b), .stall_memory(stall_b),
    .mem_ce(ce_b), .mem_addr(maddr_b), .mem_rdata(rdata_b)
  );

  // ---------------- memory models ----------------
  // Data is valid only in the cycle READ_LATENCY after the strobe; garbage otherwise
  bit         ce_seen_a, ce_seen_b;
  logic [9:0] ce_addr_seen_a, ce_addr_seen_b;
  int         rem_a = 0, rem_b = 0;
  logic [9:0] raddr_a = '0, raddr_b = '0;

  always @(negedge clk) begin
    ce_seen_a = ce_a; ce_addr_seen_a = maddr_a;
    ce_seen_b = ce_b; ce_addr_seen_b = maddr_b;
  end

  always @(posedge clk) begin
    if (ce_seen_a) begin rem_a <= 2; raddr_a <= ce_addr_seen_a; end
    else if (rem_a > 0) rem_a <= rem_a - 1;
    if (ce_seen_b) begin rem_b <= 1; raddr_b <= ce_addr_seen_b; end
    else if (rem_b > 0) rem_b <= rem_b - 1;
  end

  assign rdata_a = (rem_a == 1) ? mem[raddr_a] : 32'hDEAD_BEEF;
  assign rdata_b = (rem_b == 1) ? mem[raddr_b] : 32'hDEAD_BEEF;

  // ---------------- scoreboard monitors ----------------
  bit          pend_a = 0, pend_b = 0;
  logic [15:0] e_a, e_b;

  always @(negedge clk) begin
    if (pend_a) begin
      checks++;
      if (exp_q_a.size() == 0) begin
        errors++;
        $display("FAIL resp_a unexpected response actual=%h", out_a);
      end else begin
        e_a = exp_q_a.pop_front();
        if (out_a !== e_a) begin
          errors++;
          $display("FAIL resp_a actual=%h expected=%h", out_a, e_a);
        end
      end
    end
    pend_a = !reset && re_a && !stall_a;
    if (!re_a && stall_a) viol_a++;
  end

  always @(negedge clk) begin
    if (pend_b) begin
      checks++;
      if (exp_q_b.size() == 0) begin
        errors++;
        $display("FAIL resp_b unexpected response actual=%h", out_b);
      end else begin
        e_b = exp_q_b.pop_front();
        if (out_b !== e_b) begin
          errors++;
          $display("FAIL resp_b actual=%h expected=%h", out_b, e_b);
        end
      end
    end
    pend_b = !reset && re_b && !stall_b;
    if (!re_b && stall_b) viol_b++;
  end

  // ---------------- driver helpers ----------------
  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%h expected=%h", name, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Hold the current request until accepted; reports strobes seen on the way
  task automatic wait_accept(input bit b, output int ce_cnt, output logic [9:0] ce_addr);
    bit ok;
    ok = 0; ce_cnt = 0; ce_addr = '0;
    for (int i = 0; i < 40; i++) begin
      @(negedge clk);
      if (b ? ce_b : ce_a) begin
        ce_cnt++;
        ce_addr = b ? maddr_b : maddr_a;
      end
      if (!(b ? stall_b : stall_a)) begin
        ok = 1;
        break;
      end
    end
    checks++;
    if (!ok) begin
      errors++;
      $display("FAIL accept_timeout actual=stalled required=accepted");
    end
    tick();
    if (b) re_b = 1'b0; else re_a = 1'b0;
  endtask

  // Request expected to hit: no stall, no strobe in the same cycle
  task automatic hit_req(input logic [11:0] a, input logic inv, input logic [15:0] exp);
    re_a = 1'b1; addr_a = a; inv_a = inv;
    exp_q_a.push_back(exp);
    @(negedge clk);
    check("hit_stall", {31'd0, stall_a}, 32'd0);
    check("hit_no_ce", {31'd0, ce_a}, 32'd0);
    tick();
    re_a = 1'b0; inv_a = 1'b0;
  endtask

  // ---------------- watchdog ----------------
  initial begin
    #500000;
    $display("FAIL watchdog actual=running required=finished");
    $fatal(1, "watchdog expired");
  end

  // ---------------- stimulus ----------------
  initial begin
    int          cc;
    logic [9:0]  ca;
    logic [11:0] a;
    int          gap;

    for (int i = 0; i < 1024; i++) mem[i] = $urandom;
    mem[10'h000] = 32'h46C0_2001;
    mem[10'h001] = 32'hB510_4801;
    mem[10'h002] = 32'h4770_3001;
    mem[10'h004] = 32'hE7FE_BF00;
    mem[10'h008] = 32'h1234_ABCD;
    mem[10'h040] = 32'hA5A5_5A5A;
    mem[10'h3FF] = 32'hCAFE_F00D;

    reset = 1'b1;
    re_a = 0; inv_a = 0; addr_a = '0;
    re_b = 0; inv_b = 0; addr_b = '0;
    repeat (3) @(posedge clk);
    #1 reset = 1'b0;

    // Reset state
    @(negedge clk);
    check("rst_out_a", {16'd0, out_a}, 32'h1C00);
    check("rst_out_b", {16'd0, out_b}, 32'h1C00);
    check("rst_stall", {31'd0, stall_a}, 32'd0);
    check("rst_ce", {31'd0, ce_a}, 32'd0);
    check("rst_maddr", {22'd0, maddr_a}, 32'd0);
    tick();

    // Reset in the middle of WAIT abandons the access
    re_a = 1'b1; addr_a = 12'h000;
    tick();
    reset = 1'b1; re_a = 1'b0;
    @(negedge clk);
    check("midrst_out", {16'd0, out_a}, 32'h1C00);
    check("midrst_stall", {31'd0, stall_a}, 32'd0);
    check("midrst_ce", {31'd0, ce_a}, 32'd0);
    tick();
    reset = 1'b0;
    tick();
    re_a = 1'b1; addr_a = 12'h000;
    exp_q_a.push_back(16'h2001);
    wait_accept(0, cc, ca);
    check("post_rst_miss_ce", cc, 1);

    // Cold miss to 0x004: exact stall window and strobe
    re_a = 1'b1; addr_a = 12'h004;
    exp_q_a.push_back(16'h4801);
    for (int i = 0; i < 4; i++) begin
      @(negedge clk);
      check($sformatf("miss_stall_t%0d", i), {31'd0, stall_a}, (i < 3) ? 32'd1 : 32'd0);
      if (i == 0) begin
        check("miss_ce", {31'd0, ce_a}, 32'd1);
        check("miss_maddr", {22'd0, maddr_a}, 32'h001);
      end
      if (i == 1) check("wait_no_ce", {31'd0, ce_a}, 32'd0);
      tick();
    end

    // Back-to-back hit on the other halfword
    hit_req(12'h006, 1'b0, 16'hB510);

    // Address change during WAIT: original fill completes, then a second miss
    re_a = 1'b1; addr_a = 12'h010;
    @(negedge clk);
    check("chg_ce0", {31'd0, ce_a}, 32'd1);
    check("chg_maddr0", {22'd0, maddr_a}, 32'h004);
    tick();
    addr_a = 12'h020;
    exp_q_a.push_back(16'hABCD);
    @(negedge clk);
    check("chg_wait_maddr", {22'd0, maddr_a}, 32'h004);
    tick();
    wait_accept(0, cc, ca);
    check("chg_second_ce", cc, 1);
    check("chg_second_maddr", {22'd0, ca}, 32'h008);

    // Invalidate during WAIT: fill lands but line stays invalid
    re_a = 1'b1; addr_a = 12'h008;
    exp_q_a.push_back(16'h3001);
    tick();
    inv_a = 1'b1;
    tick();
    inv_a = 1'b0;
    wait_accept(0, cc, ca);
    check("inv_wait_refetch", cc, 1);
    check("inv_wait_maddr", {22'd0, ca}, 32'h002);

    // read_enable dropped during WAIT: no stall, output held
    re_a = 1'b1; addr_a = 12'h100;
    tick();
    re_a = 1'b0;
    for (int i = 0; i < 4; i++) begin
      @(negedge clk);
      check("drop_stall", {31'd0, stall_a}, 32'd0);
      check("drop_out_held", {16'd0, out_a}, 32'h3001);
      tick();
    end
    hit_req(12'h102, 1'b0, 16'hA5A5);

    // Invalidate in IDLE: same-cycle hit still served, next request misses
    hit_req(12'h100, 1'b1, 16'h5A5A);
    re_a = 1'b1; addr_a = 12'h102;
    exp_q_a.push_back(16'hA5A5);
    wait_accept(0, cc, ca);
    check("inv_idle_miss", cc, 1);

    // Address wrap: top word, high half
    re_a = 1'b1; addr_a = 12'hFFE;
    exp_q_a.push_back(16'hCAFE);
    wait_accept(0, cc, ca);
    check("wrap_ce", cc, 1);
    check("wrap_maddr", {22'd0, ca}, 32'h3FF);
    repeat (3) tick();
    check("queue_a_drained", exp_q_a.size(), 0);
    check("no_stall_idle_a", viol_a, 0);

    // READ_LATENCY=1 sweep against the memory model
    for (int n = 0; n < 100; n++) begin
      a = 12'($urandom_range(0, 63)) << 1;
      if ($urandom_range(0, 7) == 0) a = 12'($urandom_range(0, 4095)) & 12'hFFE;
      re_b = 1'b1; addr_b = a;
      exp_q_b.push_back(a[1] ? mem[a[11:2]][31:16] : mem[a[11:2]][15:0]);
      wait_accept(1, cc, ca);
      gap = $urandom_range(0, 2);
      repeat (gap) tick();
    end
    repeat (3) tick();
    check("queue_b_drained", exp_q_b.size(), 0);
    check("no_stall_idle_b", viol_b, 0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
